ram_march_tester: RTL



---
 rtl/ram_march_tester.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_march_tester.sv
// ram_march_tester: W0/R0/W1/R1 march test driver for a small synchronous-write RAM
module ram_march_tester #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED = DATA_W'('hA5),
    parameter int RD_LATENCY = 0,
    parameter int ERR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_phase
);
    if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
        $error("RD_LATENCY must be 0 or 1");
    end
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;
    state_t state, state_d;
    logic [ADDR_W-1:0] addr_d, next_addr, rd_addr, cmp_addr, first_err_addr_d;
    logic [DATA_W-1:0] wdata_d, exp_now, rd_exp, cmp_exp;
    logic [ERR_W-1:0] err_next, err_d;
    logic rw_d, busy_d, done_d, pass_d, first_err_phase_d;
    logic reading, drain, drain_d, rd_vld, rd_phase, cmp_vld, cmp_phase, mismatch;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return SEED + DATA_W'(a);
    endfunction

    assign next_addr = mem_addr + ADDR_W'(1);
    assign reading = state == R0 || state == R1;
    assign exp_now = state == R1 ? ~pat(mem_addr) : pat(mem_addr);
    // With a registered-read RAM the compare uses the address/expectation captured one cycle earlier
    assign cmp_vld = RD_LATENCY == 0 ? reading : rd_vld;
    assign cmp_exp = RD_LATENCY == 0 ? exp_now : rd_exp;
    assign cmp_addr = RD_LATENCY == 0 ? mem_addr : rd_addr;
    assign cmp_phase = RD_LATENCY == 0 ? state == R1 : rd_phase;
    assign mismatch = cmp_vld && mem_rdata != cmp_exp;
    assign err_next = mismatch && err_count != ERR_MAX ? err_count + ERR_W'(1) : err_count;

    always_comb begin
        state_d = state;
        addr_d = mem_addr;
        rw_d = 1'b0;
        wdata_d = '0;
        busy_d = busy;
        done_d = done;
        pass_d = pass;
        err_d = err_next;
        first_err_addr_d = mismatch && err_count == '0 ? cmp_addr : first_err_addr;
        first_err_phase_d = mismatch && err_count == '0 ? cmp_phase : first_err_phase;
        drain_d = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = W0;
                    addr_d = '0;
                    rw_d = 1'b1;
                    wdata_d = pat('0);
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    err_d = '0;
                    first_err_addr_d = '0;
                    first_err_phase_d = 1'b0;
                end
            end
            W0, W1: begin
                if (mem_addr == LAST) begin
                    state_d = state == W0 ? R0 : R1;
                    addr_d = '0;
                end else begin
                    addr_d = next_addr;
                    rw_d = 1'b1;
                    wdata_d = state == W0 ? pat(next_addr) : ~pat(next_addr);
                end
            end
            R0, R1: begin
                if (mem_addr != LAST) begin
                    addr_d = next_addr;
                end else if (RD_LATENCY == 1 && !drain) begin
                    drain_d = 1'b1;
                end else if (state == R0) begin
                    state_d = W1;
                    addr_d = '0;
                    rw_d = 1'b1;
                    wdata_d = ~pat('0);
                end else begin
                    state_d = DONE;
                    addr_d = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = err_next == '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            mem_rw <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            first_err_addr <= '0;
            first_err_phase <= 1'b0;
            drain <= 1'b0;
            rd_vld <= 1'b0;
            rd_exp <= '0;
            rd_addr <= '0;
            rd_phase <= 1'b0;
        end else begin
            state <= state_d;
            mem_rw <= rw_d;
            mem_addr <= addr_d;
            mem_wdata <= wdata_d;
            busy <= busy_d;
            done <= done_d;
            pass <= pass_d;
            err_count <= err_d;
            first_err_addr <= first_err_addr_d;
            first_err_phase <= first_err_phase_d;
            drain <= drain_d;
            rd_vld <= reading && !drain;
            rd_exp <= exp_now;
            rd_addr <= mem_addr;
            rd_phase <= state == R1;
        end
    end
endmodule
